// File: rtl/mano_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mano_pkg : shared constants for the basic-computer control path.
// Rev 1.0
// ----------------------------------------------------------------------------
package mano_pkg;

  localparam int WORD_W = 16;
  localparam int SC_W   = 3;

  // Instruction-word fields
  localparam int I_BIT  = 15;
  localparam int OP_HI  = 14;
  localparam int OP_LO  = 12;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IO  = 3'd7;

  localparam int T0_IDX = 0;
  localparam int T1_IDX = 1;
  localparam int T2_IDX = 2;
  localparam int T3_IDX = 3;
  localparam int T4_IDX = 4;
  localparam int T5_IDX = 5;
  localparam int D7_IDX = 7;

endpackage
`default_nettype wire

// File: rtl/dec_3to8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dec_3to8 : 3-bit binary to one-hot decoder; OUT_W < 8 keeps the low outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
module dec_3to8 #(
  parameter int OUT_W = 8
) (
  input  logic [2:0]       sel_i,
  output logic [OUT_W-1:0] dec_o
);

  for (genvar i = 0; i < OUT_W; i++) begin : g_dec
    assign dec_o[i] = (sel_i == 3'(i));
  end

endmodule
`default_nettype wire

// File: rtl/timing_control_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timing_control_gen : sequence counter, IR, opcode decode and indirect flop J.
// Rev 1.0
// ----------------------------------------------------------------------------
module timing_control_gen
  import mano_pkg::*;
#(
  parameter int T_STATES = 6,
  parameter int WORD_W   = mano_pkg::WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   bus_in,
  input  logic                sc_clr,
  input  logic                hlt,
  output logic [T_STATES-1:0] T,
  output logic [7:0]          D,
  output logic                J,
  output logic [WORD_W-1:0]   ir,
  output logic [SC_W-1:0]     sc
);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(T_STATES - 1);
  localparam logic [SC_W-1:0] SC_T1   = SC_W'(T1_IDX);
  localparam logic [SC_W-1:0] SC_T2   = SC_W'(T2_IDX);

  logic [SC_W-1:0]   sc_q, sc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic              j_q, j_d;

  // Clear beats halt; IR and J only load on a normally advancing edge.
  always_comb begin
    sc_d = sc_q;
    ir_d = ir_q;
    j_d  = j_q;
    if (sc_clr) begin
      sc_d = '0;
    end else if (!hlt) begin
      sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      if (sc_q == SC_T1) ir_d = bus_in;
      if (sc_q == SC_T2) j_d  = ir_q[I_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      ir_q <= '0;
      j_q  <= 1'b0;
    end else begin
      sc_q <= sc_d;
      ir_q <= ir_d;
      j_q  <= j_d;
    end
  end

  dec_3to8 #(.OUT_W(T_STATES)) u_t_dec (
    .sel_i (sc_q),
    .dec_o (T)
  );

  dec_3to8 #(.OUT_W(8)) u_d_dec (
    .sel_i (ir_q[OP_HI:OP_LO]),
    .dec_o (D)
  );

  assign J  = j_q;
  assign ir = ir_q;
  assign sc = sc_q;

endmodule
`default_nettype wire

// File: tb/tb_timing_control_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_timing_control_gen : table-driven bench for timing_control_gen.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_timing_control_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_in = '0;
  logic        sc_clr = 1'b0;
  logic        hlt = 1'b0;
  logic [5:0]  T;
  logic [7:0]  D;
  logic        J;
  logic [15:0] ir;
  logic [2:0]  sc;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  timing_control_gen #(.T_STATES(6), .WORD_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_in (bus_in),
    .sc_clr (sc_clr),
    .hlt    (hlt),
    .T      (T),
    .D      (D),
    .J      (J),
    .ir     (ir),
    .sc     (sc)
  );

  typedef struct {
    logic        r;
    logic        c;
    logic        h;
    logic [15:0] bus;
    logic [2:0]  sc;
    logic [15:0] ir;
    logic [7:0]  d;
    logic        j;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic h, input logic [15:0] bus,
                     input logic [2:0] s, input logic [15:0] i, input logic [7:0] d,
                     input logic j);
    vec_t v;
    v.r = r; v.c = c; v.h = h; v.bus = bus;
    v.sc = s; v.ir = i; v.d = d; v.j = j;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    else
      n_pass++;
  endtask

  initial begin
    // Each row: inputs held across one rising edge, outputs expected after it.
    //  rst clr hlt bus       sc  ir        D      J
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 8'h01, 0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 2, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 3, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 4, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 5, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 8'h01, 0);
    // fetch 9ABC: I=1, opcode 1
    add(0, 0, 0, 16'h9ABC, 2, 16'h9ABC, 8'h02, 0);
    add(0, 0, 0, 16'h0000, 3, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 4, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 5, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 0, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 1, 16'h9ABC, 8'h02, 1);
    // register-reference 7800, clear in T3
    add(0, 0, 0, 16'h7800, 2, 16'h7800, 8'h80, 1);
    add(0, 0, 0, 16'h0000, 3, 16'h7800, 8'h80, 0);
    add(0, 1, 0, 16'h0000, 0, 16'h7800, 8'h80, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h7800, 8'h80, 0);
    add(0, 0, 0, 16'h9ABC, 2, 16'h9ABC, 8'h02, 0);
    add(0, 0, 0, 16'h0000, 3, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 4, 16'h9ABC, 8'h02, 1);
    // halt in T4 for five cycles, then resume at T5
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 16'h0000, 4, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 5, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 0, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 1, 16'h9ABC, 8'h02, 1);
    add(0, 0, 0, 16'h1234, 2, 16'h1234, 8'h02, 1);
    add(0, 0, 0, 16'h0000, 3, 16'h1234, 8'h02, 0);
    // clear and halt together: clear wins
    add(0, 1, 1, 16'h0000, 0, 16'h1234, 8'h02, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h1234, 8'h02, 0);
    add(0, 0, 0, 16'h5678, 2, 16'h5678, 8'h20, 0);
    // reset with clear in T2: reset wins
    add(1, 1, 0, 16'h0000, 0, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h3456, 2, 16'h3456, 8'h08, 0);
    add(0, 0, 0, 16'h0000, 3, 16'h3456, 8'h08, 0);
    add(0, 0, 0, 16'h0000, 4, 16'h3456, 8'h08, 0);
    add(0, 0, 0, 16'h0000, 5, 16'h3456, 8'h08, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h3456, 8'h08, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h3456, 8'h08, 0);
    // abort fetch in T1; no load in T0 or while halted in T1
    add(0, 1, 0, 16'hFFFF, 0, 16'h3456, 8'h08, 0);
    add(0, 0, 0, 16'hFFFF, 1, 16'h3456, 8'h08, 0);
    add(0, 0, 1, 16'hFFFF, 1, 16'h3456, 8'h08, 0);
    add(0, 0, 0, 16'h0000, 2, 16'h0000, 8'h01, 0);
    add(0, 0, 0, 16'h0000, 3, 16'h0000, 8'h01, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      logic [5:0] exp_t;
      rst    = tbl[n].r;
      sc_clr = tbl[n].c;
      hlt    = tbl[n].h;
      bus_in = tbl[n].bus;
      @(posedge clk);
      #1;
      exp_t = 6'b000001 << tbl[n].sc;
      chk("sc", n, {13'd0, sc}, {13'd0, tbl[n].sc});
      chk("T",  n, {10'd0, T},  {10'd0, exp_t});
      chk("ir", n, ir, tbl[n].ir);
      chk("D",  n, {8'd0, D},   {8'd0, tbl[n].d});
      chk("J",  n, {15'd0, J},  {15'd0, tbl[n].j});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
